// File: rtl/regfile_pkg.sv
// Shared types for the register-file write-back path.
// Index/data widths, queue entry layout and a one-hot helper.
package regfile_pkg;

  localparam int NUM_REGS  = 16;
  localparam int DATA_W    = 16;
  localparam int REG_IDX_W = $clog2(NUM_REGS);
  localparam int WB_DEPTH  = 4;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0]    data_t;
  typedef logic [NUM_REGS-1:0]  reg_mask_t;

  typedef struct packed {
    reg_idx_t rd;
    data_t    data;
  } wb_entry_t;

  function automatic reg_mask_t onehot(input reg_idx_t r);
    reg_mask_t m;
    m    = '0;
    m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/regfile_write_ctrl_if.sv
// Write-back request/retire bundle between the pipeline and the
// register-file write controller; stall_cnt only with RF_WB_STALL_CNT_EN.
interface regfile_write_ctrl_if;
  import regfile_pkg::*;

  logic      alu_valid;
  logic      alu_ready;
  reg_idx_t  alu_reg;
  data_t     alu_data;
  logic      mem_valid;
  logic      mem_ready;
  reg_idx_t  mem_reg;
  data_t     mem_data;
  logic      rf_hold;
  reg_mask_t write_reg;
  data_t     write_data;
  reg_mask_t pending;
`ifdef RF_WB_STALL_CNT_EN
  logic [15:0] stall_cnt;

  modport master (
    output alu_valid, alu_reg, alu_data,
    output mem_valid, mem_reg, mem_data,
    output rf_hold,
    input  alu_ready, mem_ready,
    input  write_reg, write_data, pending,
    input  stall_cnt
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data,
    input  mem_valid, mem_reg, mem_data,
    input  rf_hold,
    output alu_ready, mem_ready,
    output write_reg, write_data, pending,
    output stall_cnt
  );
`else
  modport master (
    output alu_valid, alu_reg, alu_data,
    output mem_valid, mem_reg, mem_data,
    output rf_hold,
    input  alu_ready, mem_ready,
    input  write_reg, write_data, pending
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data,
    input  mem_valid, mem_reg, mem_data,
    input  rf_hold,
    output alu_ready, mem_ready,
    output write_reg, write_data, pending
  );
`endif

endinterface

// File: rtl/regfile_write_ctrl_wb_fifo.sv
// Circular write-back queue of wb_entry_t with a per-slot valid view
// so the controller can build the pending scoreboard.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  wb_entry_t              push_entry,
  input  logic                   pop,
  output wb_entry_t              head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic [DEPTH-1:0]       entry_vld,
  output reg_idx_t               entry_rd [DEPTH]
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  wb_entry_t        mem [DEPTH];

  // Pointers and occupancy; reset drops every queued entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  // Entry storage; only slots inside the valid window are ever read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

  // A slot is live when its distance from the head is below count.
  always_comb begin
    logic [PTR_W-1:0] off;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off          = PTR_W'(i) - rd_ptr;
      entry_vld[i] = ({1'b0, off} < count);
      entry_rd[i]  = mem[i].rd;
    end
  end

endmodule

// File: rtl/regfile_write_ctrl.sv
// Register-file write-back driver: round-robin ALU/MEM intake, R0 filter,
// FIFO retire as one-hot enable. RF_WB_STALL_CNT_EN adds stall_cnt.
module regfile_write_ctrl
  import regfile_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input logic                 clk,
  input logic                 rst,
  regfile_write_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             prio_mem;
  logic             room;
  logic             gnt_alu;
  logic             gnt_mem;
  logic             take;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] count;
  logic             empty;
  wb_entry_t        head;
  wb_entry_t        sel;
  logic [DEPTH-1:0] entry_vld;
  reg_idx_t         entry_rd [DEPTH];
  data_t            last_data;
  reg_mask_t        pend;

  // Readiness looks only at the registered count: no pass-through
  // when the queue is full, even if the head retires this cycle.
  assign room    = (count < CNT_W'(DEPTH));
  assign gnt_alu = bus.alu_valid & (~bus.mem_valid | ~prio_mem);
  assign gnt_mem = bus.mem_valid & (~bus.alu_valid | prio_mem);

  assign bus.alu_ready = gnt_alu & room;
  assign bus.mem_ready = gnt_mem & room;

  assign take = bus.alu_ready | bus.mem_ready;

  // Select the accepted request.
  always_comb begin
    sel = '0;
    if (bus.alu_ready) begin
      sel.rd   = bus.alu_reg;
      sel.data = bus.alu_data;
    end else if (bus.mem_ready) begin
      sel.rd   = bus.mem_reg;
      sel.data = bus.mem_data;
    end
  end

  // R0 writes are acknowledged but never queued.
  assign push = take & (sel.rd != '0);
  assign pop  = ~empty & ~bus.rf_hold;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (sel),
    .pop        (pop),
    .head       (head),
    .count      (count),
    .empty      (empty),
    .entry_vld  (entry_vld),
    .entry_rd   (entry_rd)
  );

  // Round-robin flag flips only on a grant made under contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      prio_mem <= 1'b0;
    else if (bus.alu_valid && bus.mem_valid && take)
      prio_mem <= ~prio_mem;
  end

  // Remember the last retired data so write_data holds when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_data <= '0;
    else if (pop)
      last_data <= head.data;
  end

  assign bus.write_reg  = pop ? onehot(head.rd) : '0;
  assign bus.write_data = pop ? head.data : last_data;

  // Scoreboard: every live queue slot marks its target register.
  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++)
      if (entry_vld[i]) pend = pend | onehot(entry_rd[i]);
  end

  assign bus.pending = pend;

`ifdef RF_WB_STALL_CNT_EN
  logic [1:0]  stall_inc;
  logic [16:0] stall_sum;
  logic [15:0] stall_q;

  assign stall_inc =
    2'(bus.alu_valid & ~bus.alu_ready) +
    2'(bus.mem_valid & ~bus.mem_ready);
  assign stall_sum = {1'b0, stall_q} + 17'(stall_inc);

  // Saturating count of source-cycles spent waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_q <= '0;
    else
      stall_q <= stall_sum[16] ? 16'hFFFF : stall_sum[15:0];
  end

  assign bus.stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Directed bench for regfile_write_ctrl with a write-back scoreboard.
// Expected retires are queued on acceptance and popped on write_reg.
module tb_regfile_write_ctrl;
  import regfile_pkg::*;

  typedef struct {
    reg_mask_t mask;
    data_t     data;
  } exp_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  exp_t sb [$];

  regfile_write_ctrl_if bus ();

  regfile_write_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic v, input reg_idx_t r,
                         input data_t d);
    bus.alu_valid = v;
    bus.alu_reg   = r;
    bus.alu_data  = d;
  endtask

  task automatic set_mem(input logic v, input reg_idx_t r,
                         input data_t d);
    bus.mem_valid = v;
    bus.mem_reg   = r;
    bus.mem_data  = d;
  endtask

  function automatic reg_mask_t bit_of(input int r);
    reg_mask_t m;
    m = '0;
    m[r] = 1'b1;
    return m;
  endfunction

  // Retire monitor: every nonzero write_reg must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.write_reg != '0) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", 32'(bus.write_reg), 32'h0);
      end else begin
        e = sb.pop_front();
        chk("retire_reg", 32'(bus.write_reg), 32'(e.mask));
        chk("retire_data", 32'(bus.write_data), 32'(e.data));
      end
    end
  end

  initial begin
    bit exp_mem;
    int cnt;
    bit rdy;

    tests = 0;
    fails = 0;
    rst   = 1'b1;
    bus.rf_hold = 1'b0;
    set_alu(1'b0, '0, '0);
    set_mem(1'b0, '0, '0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_write_reg", 32'(bus.write_reg), 32'h0);
    chk("rst_write_data", 32'(bus.write_data), 32'h0);
    chk("rst_pending", 32'(bus.pending), 32'h0);
    chk("rst_alu_ready", 32'(bus.alu_ready), 32'h0);
`ifdef RF_WB_STALL_CNT_EN
    chk("rst_stall", 32'(bus.stall_cnt), 32'h0);
`endif
    tick();
    rst = 1'b0;

    // Single write to R3
    set_alu(1'b1, 4'd3, 16'hBEEF);
    @(negedge clk);
    chk("t1_alu_ready", 32'(bus.alu_ready), 32'h1);
    chk("t1_mem_ready", 32'(bus.mem_ready), 32'h0);
    sb.push_back('{16'h0008, 16'hBEEF});
    tick();
    set_alu(1'b0, '0, '0);
    @(negedge clk);
    chk("t1_pending_set", 32'(bus.pending), 32'h0008);
    tick();
    @(negedge clk);
    chk("t1_pending_clr", 32'(bus.pending), 32'h0);
    chk("t1_idle_reg", 32'(bus.write_reg), 32'h0);
    chk("t1_hold_data", 32'(bus.write_data), 32'hBEEF);
    tick();

    // Contention: grants alternate starting with ALU
    exp_mem = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_alu(1'b1, 4'd6, data_t'(16'h6000 + k));
      set_mem(1'b1, 4'd5, data_t'(16'h5000 + k));
      @(negedge clk);
      chk("t2_alu_ready", 32'(bus.alu_ready), 32'(!exp_mem));
      chk("t2_mem_ready", 32'(bus.mem_ready), 32'(exp_mem));
      if (exp_mem)
        sb.push_back('{bit_of(5), data_t'(16'h5000 + k)});
      else
        sb.push_back('{bit_of(6), data_t'(16'h6000 + k)});
      exp_mem = !exp_mem;
      tick();
    end
    set_alu(1'b0, '0, '0);
    set_mem(1'b0, '0, '0);
    repeat (3) tick();
    chk("t2_drained", 32'(sb.size()), 32'h0);

    // Full queue under hold, then release
    bus.rf_hold = 1'b1;
    cnt = 0;
    for (int k = 1; k <= 5; k++) begin
      set_alu(1'b1, reg_idx_t'(k), data_t'(16'h1000 + k));
      @(negedge clk);
      rdy = (cnt < 4);
      chk("t3_alu_ready", 32'(bus.alu_ready), 32'(rdy));
      chk("t3_hold_reg", 32'(bus.write_reg), 32'h0);
      if (rdy) begin
        sb.push_back('{bit_of(k), data_t'(16'h1000 + k)});
        cnt++;
      end
      tick();
    end
    @(negedge clk);
    chk("t3_pending_full", 32'(bus.pending), 32'h001E);
    tick();
    bus.rf_hold = 1'b0;
    @(negedge clk);
    chk("t3_no_passthru", 32'(bus.alu_ready), 32'h0);
    tick();
    @(negedge clk);
    chk("t3_r5_ready", 32'(bus.alu_ready), 32'h1);
    sb.push_back('{bit_of(5), 16'h1005});
    tick();
    set_alu(1'b0, '0, '0);
    repeat (4) tick();
    chk("t3_drained", 32'(sb.size()), 32'h0);
`ifdef RF_WB_STALL_CNT_EN
    chk("t3_stall_cnt", 32'(bus.stall_cnt), 32'd7);
`endif

    // R0 write is acknowledged and dropped
    set_mem(1'b1, 4'd0, 16'h1234);
    @(negedge clk);
    chk("t4_mem_ready", 32'(bus.mem_ready), 32'h1);
    tick();
    set_mem(1'b0, '0, '0);
    @(negedge clk);
    chk("t4_no_write", 32'(bus.write_reg), 32'h0);
    chk("t4_no_pending", 32'(bus.pending), 32'h0);
    chk("t4_data_hold", 32'(bus.write_data), 32'h1005);
    tick();

    // Two writes to R7 retire in order
    set_alu(1'b1, 4'd7, 16'h0001);
    @(negedge clk);
    chk("t5_alu_ready", 32'(bus.alu_ready), 32'h1);
    sb.push_back('{16'h0080, 16'h0001});
    tick();
    set_alu(1'b0, '0, '0);
    set_mem(1'b1, 4'd7, 16'h0002);
    @(negedge clk);
    chk("t5_mem_ready", 32'(bus.mem_ready), 32'h1);
    chk("t5_pending_a", 32'(bus.pending), 32'h0080);
    sb.push_back('{16'h0080, 16'h0002});
    tick();
    set_mem(1'b0, '0, '0);
    @(negedge clk);
    chk("t5_pending_b", 32'(bus.pending), 32'h0080);
    tick();
    @(negedge clk);
    chk("t5_pending_clr", 32'(bus.pending), 32'h0);
    chk("t5_drained", 32'(sb.size()), 32'h0);
    tick();

    // Queue three, then reset between edges
    bus.rf_hold = 1'b1;
    set_alu(1'b1, 4'd8, 16'h2000);
    set_mem(1'b1, 4'd9, 16'h2001);
    @(negedge clk);
    chk("t6_alu_first", 32'(bus.alu_ready), 32'h1);
    tick();
    set_alu(1'b0, '0, '0);
    @(negedge clk);
    chk("t6_mem_ready", 32'(bus.mem_ready), 32'h1);
    tick();
    set_mem(1'b0, '0, '0);
    set_alu(1'b1, 4'd10, 16'h2002);
    @(negedge clk);
    chk("t6_alu_third", 32'(bus.alu_ready), 32'h1);
    tick();
    set_alu(1'b0, '0, '0);
    @(negedge clk);
    chk("t6_pending_q", 32'(bus.pending), 32'h0700);
    tick();
    bus.rf_hold = 1'b0;
    #1;
    chk("t6_pre_write", 32'(bus.write_reg), 32'h0100);
    rst = 1'b1;
    #1;
    chk("t6_rst_reg", 32'(bus.write_reg), 32'h0);
    chk("t6_rst_pending", 32'(bus.pending), 32'h0);
`ifdef RF_WB_STALL_CNT_EN
    chk("t6_rst_stall", 32'(bus.stall_cnt), 32'h0);
`endif
    sb.delete();
    @(posedge clk);
    #3;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6_post_reg", 32'(bus.write_reg), 32'h0);
      chk("t6_post_pend", 32'(bus.pending), 32'h0);
    end
    tick();

    // Round-robin priority restarts at ALU after reset
    set_alu(1'b1, 4'd12, 16'h3000);
    set_mem(1'b1, 4'd13, 16'h3001);
    @(negedge clk);
    chk("t6_rr_alu", 32'(bus.alu_ready), 32'h1);
    chk("t6_rr_mem", 32'(bus.mem_ready), 32'h0);
    sb.push_back('{bit_of(12), 16'h3000});
    tick();
    set_alu(1'b0, '0, '0);
    set_mem(1'b0, '0, '0);
    repeat (3) tick();
    chk("t6_drained", 32'(sb.size()), 32'h0);
`ifdef RF_WB_STALL_CNT_EN
    chk("t6_stall_cnt", 32'(bus.stall_cnt), 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
